window_stats_acc: RTL and testbench

Parametrised sliding-window accumulator for the sample-statistics path: it keeps the last N unsigned samples and maintains their running sum and running sum of squares. Downstream mean/variance logic consumes these values. The window length N is programmable at run time up to DEPTH. Updates are incremental (add the newest sample, subtract the evicted one), so per-sample cost is constant. It adds occupancy, full and valid status, plus a synchronous window clear.

---
 rtl/window_stats_acc.sv | 126 ++++++++++++
 tb/tb_window_stats_acc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/window_stats_acc.sv
// Sliding-window accumulator: keeps the last len_q unsigned samples and
// maintains their running sum and running sum of squares incrementally
// (add newest, subtract evicted). Window length is reloaded on RESET/CLEAR.
module window_stats_acc #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 14,
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int SUM_W = DATA_W + $clog2(DEPTH),
  localparam int SQ_W  = 2 * DATA_W + $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              SAMPLE,
  input  logic [DATA_W-1:0] TN,
  output logic [SUM_W-1:0]  Tsum,
  output logic [SQ_W-1:0]   Tsum_square,
  output logic [LEN_W-1:0]  COUNT,
  output logic              FULL,
  output logic              VALID
);

  localparam int PTR_W = $clog2(DEPTH);

  // FILLING: window not yet full, nothing evicted. STEADY: evict every sample.
  typedef enum logic {FILLING, STEADY} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SQ_W-1:0]   sq_q, sq_d;
  logic              valid_q, valid_d;

  logic [LEN_W-1:0]  len_clamp;
  logic [DATA_W-1:0] old;
  logic [SQ_W-1:0]   tn_sq, old_sq;
  logic              accept;
  logic              ptr_last;

  // Sample storage; never read before written since eviction is gated by STEADY.
  logic [DATA_W-1:0] buf_q [DEPTH];

  // Clamp the requested length into 1..DEPTH.
  always_comb begin
    len_clamp = LEN;
    if (LEN == '0)
      len_clamp = LEN_W'(1);
    else if (LEN > LEN_W'(DEPTH))
      len_clamp = LEN_W'(DEPTH);
  end

  // Eviction operand and the two square products for this cycle.
  always_comb begin
    accept   = SAMPLE && !RESET && !CLEAR;
    old      = (state_q == STEADY) ? buf_q[wr_ptr_q] : '0;
    tn_sq    = SQ_W'(TN) * SQ_W'(TN);
    old_sq   = SQ_W'(old) * SQ_W'(old);
    ptr_last = (LEN_W'(wr_ptr_q) == len_q - LEN_W'(1));
  end

  // Next-state: RESET/CLEAR flush beats an accepted sample; idle holds.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    sq_d     = sq_q;
    valid_d  = 1'b0;
    if (RESET || CLEAR) begin
      state_d  = FILLING;
      len_d    = len_clamp;
      count_d  = '0;
      wr_ptr_d = '0;
      sum_d    = '0;
      sq_d     = '0;
    end else if (SAMPLE) begin
      valid_d  = 1'b1;
      sum_d    = sum_q + SUM_W'(TN) - SUM_W'(old);
      sq_d     = sq_q + tn_sq - old_sq;
      wr_ptr_d = ptr_last ? '0 : wr_ptr_q + PTR_W'(1);
      if (state_q == FILLING) begin
        count_d = count_q + LEN_W'(1);
        if (count_q + LEN_W'(1) == len_q)
          state_d = STEADY;
      end
    end
  end

  // Control and accumulator registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FILLING;
      len_q    <= len_clamp;
      count_q  <= '0;
      wr_ptr_q <= '0;
      sum_q    <= '0;
      sq_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
      sq_q     <= sq_d;
      valid_q  <= valid_d;
    end
  end

  // Store the accepted sample at the write pointer.
  always_ff @(posedge CLK) begin
    if (accept)
      buf_q[wr_ptr_q] <= TN;
  end

  assign Tsum        = sum_q;
  assign Tsum_square = sq_q;
  assign COUNT       = count_q;
  assign FULL        = (state_q == STEADY);
  assign VALID       = valid_q;

endmodule

// File: tb/tb_window_stats_acc.sv
// Randomized + directed bench for window_stats_acc against a queue-based
// model of the window contents.
module tb_window_stats_acc;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 14;
  localparam int LEN_W  = 4;
  localparam int SUM_W  = 16;
  localparam int SQ_W   = 28;

  logic              CLK = 1'b0;
  logic              RESET, CLEAR, SAMPLE;
  logic [LEN_W-1:0]  LEN;
  logic [DATA_W-1:0] TN;
  logic [SUM_W-1:0]  Tsum;
  logic [SQ_W-1:0]   Tsum_square;
  logic [LEN_W-1:0]  COUNT;
  logic              FULL, VALID;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int     win[$];
  int     mlen = 1;
  bit     mvalid = 0;
  bit     started = 0;

  window_stats_acc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .LEN(LEN), .SAMPLE(SAMPLE),
    .TN(TN), .Tsum(Tsum), .Tsum_square(Tsum_square), .COUNT(COUNT),
    .FULL(FULL), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the window is simply the last mlen accepted samples.
  always @(posedge CLK) begin
    if (RESET || CLEAR) begin
      mlen = (LEN == 0) ? 1 : ((int'(LEN) > DEPTH) ? DEPTH : int'(LEN));
      win.delete();
      mvalid = 0;
      if (RESET) started = 1;
    end else if (SAMPLE) begin
      win.push_back(int'(TN));
      if (win.size() > mlen) void'(win.pop_front());
      mvalid = 1;
    end else begin
      mvalid = 0;
    end
  end

  // Compare every cycle once the model is anchored by a reset.
  always @(negedge CLK) begin
    if (started) begin
      longint s, sq;
      s = 0; sq = 0;
      foreach (win[i]) begin
        s  += win[i];
        sq += longint'(win[i]) * win[i];
      end
      chk("model_tsum",  Tsum, s);
      chk("model_tsq",   Tsum_square, sq);
      chk("model_count", COUNT, win.size());
      chk("model_full",  FULL, win.size() == mlen);
      chk("model_valid", VALID, mvalid);
    end
  end

  task automatic send(input int v);
    SAMPLE = 1'b1; TN = DATA_W'(v);
    @(negedge CLK);
    SAMPLE = 1'b0;
  endtask

  task automatic idle(input int n);
    SAMPLE = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr(input int l);
    CLEAR = 1'b1; LEN = LEN_W'(l); SAMPLE = 1'b0;
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CLEAR = 1'b0; SAMPLE = 1'b0; TN = '0; LEN = 4'd14;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_tsum", Tsum, 0);
    chk("rst_tsq", Tsum_square, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_full", FULL, 0);
    chk("rst_valid", VALID, 0);

    // full window of 14, then two evictions
    for (int v = 1; v <= 16; v++) begin
      send(v);
      chk("seq_valid", VALID, 1);
      if (v == 14) begin
        chk("w14_tsum", Tsum, 105);
        chk("w14_tsq", Tsum_square, 1015);
        chk("w14_full", FULL, 1);
        chk("w14_count", COUNT, 14);
      end
      if (v == 15) begin
        chk("w15_tsum", Tsum, 119);
        chk("w15_tsq", Tsum_square, 1239);
      end
      if (v == 16) begin
        chk("w16_tsum", Tsum, 133);
        chk("w16_tsq", Tsum_square, 1491);
      end
    end
    idle(1);
    chk("idle_valid", VALID, 0);
    chk("idle_hold", Tsum, 133);

    // length 4
    clr(4);
    for (int v = 10; v <= 50; v += 10) begin
      send(v);
      if (v == 40) begin
        chk("l4_40_tsum", Tsum, 100);
        chk("l4_40_full", FULL, 1);
      end
      if (v == 50) begin
        chk("l4_50_tsum", Tsum, 140);
        chk("l4_50_tsq", Tsum_square, 5400);
      end
    end

    // LEN=0 clamps to 1
    clr(0);
    send(7);
    chk("l1_tsum_a", Tsum, 7);
    chk("l1_tsq_a", Tsum_square, 49);
    chk("l1_cnt_a", COUNT, 1);
    send(9);
    chk("l1_tsum_b", Tsum, 9);
    chk("l1_tsq_b", Tsum_square, 81);
    chk("l1_cnt_b", COUNT, 1);

    // max values
    clr(14);
    repeat (14) send(4095);
    chk("max_tsum", Tsum, 57330);
    chk("max_tsq", Tsum_square, 234766350);

    // CLEAR with concurrent sample after a partial window
    clr(6);
    send(3); send(4); send(5);
    CLEAR = 1'b1; SAMPLE = 1'b1; TN = 12'd5; LEN = 4'd6;
    @(negedge CLK);
    CLEAR = 1'b0; SAMPLE = 1'b0;
    chk("clrs_tsum", Tsum, 0);
    chk("clrs_count", COUNT, 0);
    chk("clrs_valid", VALID, 0);
    send(8); send(1);
    idle(3);
    chk("gap_tsum", Tsum, 9);
    chk("gap_tsq", Tsum_square, 65);
    chk("gap_count", COUNT, 2);

    // RESET mid-stream
    clr(14);
    for (int v = 3; v <= 16; v++) send(v);
    RESET = 1'b1; LEN = 4'd14;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mrst_tsum", Tsum, 0);
    chk("mrst_tsq", Tsum_square, 0);
    chk("mrst_count", COUNT, 0);
    send(2);
    chk("mrst2_tsum", Tsum, 2);
    chk("mrst2_tsq", Tsum_square, 4);
    chk("mrst2_count", COUNT, 1);

    // random traffic: sample gaps, LEN wiggles, occasional CLEAR/RESET
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      LEN    = LEN_W'($urandom_range(0, 15));
      RESET  = (r < 3);
      CLEAR  = (r >= 3 && r < 15);
      SAMPLE = ($urandom_range(0, 9) < 7);
      TN     = ($urandom_range(0, 7) == 0) ? 12'hFFF : DATA_W'($urandom);
      @(negedge CLK);
    end
    RESET = 1'b0; CLEAR = 1'b0; SAMPLE = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
